// File: rtl/trace_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// trace_cmd_dispatcher
//
// Front-end stage ahead of the L1 cache model. Accepts decoded trace records
// (4-bit command + address), buffers them in an in-order FIFO, drops illegal
// command codes and issues records to the cache over a valid/ready handshake.
// CLR (8) and PRINT (9) are serializing barriers: they are only issued once
// every previously issued command has been reported complete via cache_done.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    trace record input handshake (in_ready = FIFO not full)
//   in_cmd, in_addr      trace record command code and address
//   out_valid/out_ready  record issue handshake towards the cache
//   out_cmd, out_addr    issued record (registered, held while stalled)
//   cache_done           one-cycle pulse: one non-barrier command completed
//   busy                 FIFO non-empty or commands outstanding
//   err_pulse            one-cycle pulse: dropped illegal code or spurious done
//
// Optional build macro DISPATCH_STATS_EN adds saturating 32-bit event counters
// stat_rd, stat_wr, stat_if, stat_snp (L2_INVAL/L2_DATA_RQ) and stat_drop.
// -----------------------------------------------------------------------------
module trace_cmd_dispatcher #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 8,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [3:0]        in_cmd,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              in_ready,
  output logic              out_valid,
  output logic [3:0]        out_cmd,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_ready,
  input  logic              cache_done,
  output logic              busy,
  output logic              err_pulse
`ifdef DISPATCH_STATS_EN
  ,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_wr,
  output logic [31:0]       stat_if,
  output logic [31:0]       stat_snp,
  output logic [31:0]       stat_drop
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef logic [PW:0]   ptr_t;
  typedef logic [PW-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    BARRIER
  } state_t;

  function automatic logic is_legal(input logic [3:0] c);
    return (c <= 4'd4) || (c == 4'd8) || (c == 4'd9);
  endfunction

  function automatic logic is_barrier(input logic [3:0] c);
    return (c == 4'd8) || (c == 4'd9);
  endfunction

  logic [ADDR_W+3:0] mem [DEPTH];
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;
  ptr_t              fifo_cnt;
  logic [3:0]        out_cnt;
  logic [3:0]        cnt_next;
  state_t            state;

  logic              handshake;
  logic              push;
  logic              illegal_in;
  logic              done_ok;
  logic              spurious;
  logic              issue_inc;
  logic              load;

  idx_t              head_idx;
  logic              head_avail;
  logic [3:0]        head_cmd;
  logic [ADDR_W-1:0] head_addr;

  state_t            nxt_state;
  logic              nxt_valid;

  assign fifo_cnt   = wr_ptr - rd_ptr;
  assign in_ready   = (fifo_cnt != ptr_t'(DEPTH));
  assign busy       = (fifo_cnt != '0) || (out_cnt != '0);

  assign handshake  = out_valid && out_ready;
  assign push       = in_valid && in_ready && is_legal(in_cmd);
  assign illegal_in = in_valid && in_ready && !is_legal(in_cmd);
  assign done_ok    = cache_done && (out_cnt != '0);
  assign spurious   = cache_done && (out_cnt == '0);
  assign issue_inc  = handshake && !is_barrier(out_cmd);

  always_comb begin
    cnt_next = out_cnt;
    if (issue_inc && !done_ok) begin
      cnt_next = out_cnt + 4'd1;
    end else if (!issue_inc && done_ok) begin
      cnt_next = out_cnt - 4'd1;
    end
  end

  // The output registers look one entry ahead: when the current head is being
  // handshaken this cycle, the record presented next is the one behind it.
  // A record pushed this very cycle is never bypassed to the output.
  always_comb begin
    if (handshake) begin
      head_idx   = rd_ptr[PW-1:0] + idx_t'(1);
      head_avail = (fifo_cnt > ptr_t'(1));
    end else begin
      head_idx   = rd_ptr[PW-1:0];
      head_avail = (fifo_cnt != '0);
    end
    {head_cmd, head_addr} = mem[head_idx];
  end

  // Next presentation decision for the selected head. A barrier is only
  // presented once the counter has already been zero for a full cycle and no
  // new non-barrier issue is landing on this edge.
  always_comb begin
    nxt_state = IDLE;
    nxt_valid = 1'b0;
    if (head_avail) begin
      if (is_barrier(head_cmd)) begin
        if ((out_cnt == '0) && (cnt_next == '0)) begin
          nxt_state = BARRIER;
          nxt_valid = 1'b1;
        end else begin
          nxt_state = DRAIN;
        end
      end else begin
        nxt_state = ISSUE;
        nxt_valid = (cnt_next < 4'(MAX_OUT));
      end
    end
  end

  // A presented record is held until accepted; otherwise re-evaluate.
  always_comb begin
    unique case (state)
      IDLE, DRAIN:    load = 1'b1;
      ISSUE, BARRIER: load = !out_valid || out_ready;
      default:        load = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= {in_cmd, in_addr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_cnt   <= '0;
      state     <= IDLE;
      out_valid <= 1'b0;
      out_cmd   <= '0;
      out_addr  <= '0;
      err_pulse <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end
      if (handshake) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end
      out_cnt   <= cnt_next;
      err_pulse <= illegal_in || spurious;
      if (load) begin
        state     <= nxt_state;
        out_valid <= nxt_valid;
        if (head_avail) begin
          out_cmd  <= head_cmd;
          out_addr <= head_addr;
        end
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd   <= '0;
      stat_wr   <= '0;
      stat_if   <= '0;
      stat_snp  <= '0;
      stat_drop <= '0;
    end else begin
      if (handshake && (out_cmd == 4'd0)) stat_rd <= sat_inc(stat_rd);
      if (handshake && (out_cmd == 4'd1)) stat_wr <= sat_inc(stat_wr);
      if (handshake && (out_cmd == 4'd2)) stat_if <= sat_inc(stat_if);
      if (handshake && ((out_cmd == 4'd3) || (out_cmd == 4'd4))) begin
        stat_snp <= sat_inc(stat_snp);
      end
      if (illegal_in) stat_drop <= sat_inc(stat_drop);
    end
  end
`endif

endmodule

// File: tb/tb_trace_cmd_dispatcher.sv
// -----------------------------------------------------------------------------
// Testbench for trace_cmd_dispatcher. Transaction-level reference: a queue of
// accepted legal records, an outstanding-command count and the expected error
// pulse, checked every cycle, plus directed timing steps and a random phase.
// -----------------------------------------------------------------------------
module tb_trace_cmd_dispatcher;

  localparam int MAXO = 4;
  localparam int DEP  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  in_cmd = '0;
  logic [31:0] in_addr = '0;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_cmd;
  logic [31:0] out_addr;
  logic        out_ready = 1'b0;
  logic        cache_done = 1'b0;
  logic        busy;
  logic        err_pulse;
`ifdef DISPATCH_STATS_EN
  logic [31:0] stat_rd, stat_wr, stat_if, stat_snp, stat_drop;
`endif

  trace_cmd_dispatcher #(.ADDR_W(32), .DEPTH(DEP), .MAX_OUT(MAXO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_cmd(in_cmd), .in_addr(in_addr), .in_ready(in_ready),
    .out_valid(out_valid), .out_cmd(out_cmd), .out_addr(out_addr), .out_ready(out_ready),
    .cache_done(cache_done), .busy(busy), .err_pulse(err_pulse)
`ifdef DISPATCH_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_if(stat_if),
    .stat_snp(stat_snp), .stat_drop(stat_drop)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference state
  logic [35:0] q[$];
  int          m_out = 0;
  logic        err_exp = 1'b0;
  int          cyc = 0;
  int          hs_total = 0;
  int          err_seen = 0;
  int          dq[$];
  int          done_mode = 0;
  int          done_dly = 1;
  logic [3:0]  legal_tab [7] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9};

  function automatic logic legal(input logic [3:0] c);
    return (c <= 4'd4) || (c == 4'd8) || (c == 4'd9);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input int m, input int d);
    if (m != 0 && done_mode == 0) begin
      for (int i = 0; i < m_out; i++) dq.push_back(cyc + 1 + i);
    end
    if (m == 0) begin
      dq.delete();
      cache_done = 1'b0;
    end
    done_mode = m;
    done_dly  = d;
  endtask

  task automatic tick();
    logic        hs, pu, dn, r, hold;
    logic [3:0]  hcmd, icmd;
    logic [31:0] haddr, iaddr;
    int          ob, due;
    hs = out_valid && out_ready; hcmd = out_cmd; haddr = out_addr;
    pu = in_valid && in_ready; icmd = in_cmd; iaddr = in_addr;
    dn = cache_done; r = rst; hold = out_valid && !out_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (r) begin
      q.delete(); dq.delete(); m_out = 0; err_exp = 1'b0;
    end else begin
      ob = m_out;
      err_exp = 1'b0;
      if (hs) begin
        hs_total++;
        if (q.size() == 0) begin
          chk("issue_without_record", 1, 0);
        end else begin
          chk("order_cmd", hcmd, q[0][35:32]);
          chk("order_addr", haddr, q[0][31:0]);
          if (q[0][35:32] == 4'd8 || q[0][35:32] == 4'd9) begin
            chk("barrier_after_completion", ob, 0);
          end else begin
            chk("max_outstanding", ob < MAXO, 1);
            m_out++;
            if (done_mode != 0) begin
              due = (done_mode == 1) ? cyc + done_dly : cyc + int'($urandom_range(1, 8));
              if (dq.size() > 0 && due <= dq[$]) due = dq[$] + 1;
              dq.push_back(due);
            end
          end
          void'(q.pop_front());
        end
      end
      if (dn) begin
        if (ob == 0) err_exp = 1'b1;
        else m_out--;
      end
      if (pu) begin
        if (legal(icmd)) q.push_back({icmd, iaddr});
        else err_exp = 1'b1;
      end
    end
    if (err_pulse === 1'b1) err_seen++;
    chk("err_pulse", err_pulse, err_exp);
    chk("busy", busy, (q.size() != 0) || (m_out != 0));
    chk("in_ready", in_ready, q.size() < DEP);
    if (q.size() == 0) chk("valid_when_empty", out_valid, 0);
    if (hold && !r) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_cmd", out_cmd, hcmd);
      chk("hold_addr", out_addr, haddr);
    end
    if (done_mode != 0) begin
      cache_done = 1'b0;
      if (dq.size() > 0 && dq[0] <= cyc) begin
        cache_done = 1'b1;
        void'(dq.pop_front());
      end
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [31:0] a);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_cmd = c; in_addr = a;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("push_accepted", acc, 1);
  endtask

  task automatic drain();
    logic ok;
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (done_mode == 0) set_mode(1, 1);
    ok = (q.size() == 0 && m_out == 0 && dq.size() == 0);
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      ok = (q.size() == 0 && m_out == 0 && dq.size() == 0);
    end
    chk("drain_complete", ok, 1);
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   h0, e0;
    logic a, found;

    // reset values
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cmd", out_cmd, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_pulse, 0);

    // single READ: 1-cycle presentation latency, busy until done
    out_ready = 1'b1;
    in_valid = 1'b1; in_cmd = 4'd0; in_addr = 32'h0000_1000;
    tick();
    in_valid = 1'b0;
    chk("lat_not_yet", out_valid, 0);
    tick();
    chk("lat_valid", out_valid, 1);
    chk("lat_cmd", out_cmd, 0);
    chk("lat_addr", out_addr, 32'h0000_1000);
    tick();
    chk("lat_busy_outstanding", busy, 1);
    cache_done = 1'b1; tick(); cache_done = 1'b0;
    chk("lat_busy_clear", busy, 0);
    tick();

    // fill FIFO with out_ready low; ninth record held by the source
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(4'd1, 32'h100 + 32'(i));
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_cmd = 4'd1; in_addr = 32'h108;
    tick(); tick(); tick();
    chk("full_still_blocked", in_ready, 0);
    out_ready = 1'b1;
    set_mode(1, 2);
    a = 1'b0;
    for (int i = 0; i < 50 && !a; i++) begin
      a = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("ninth_accepted", a, 1);
    drain();

    // barrier waits for completions
    set_mode(1, 5);
    out_ready = 1'b1;
    push(4'd1, 32'h2000);
    push(4'd0, 32'h2004);
    push(4'd8, 32'h0);
    push(4'd0, 32'h2008);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_out == 0 && q.size() > 0 && q[0][35:32] == 4'd8) found = 1'b1;
      else tick();
    end
    chk("barrier_drain_reached", found, 1);
    chk("barrier_not_early", out_valid, 0);
    tick();
    chk("barrier_presented", out_valid, 1);
    chk("barrier_cmd", out_cmd, 8);
    drain();

    // MAX_OUT stall
    set_mode(0, 0);
    out_ready = 1'b1;
    h0 = hs_total;
    for (int i = 0; i < 6; i++) push(4'd0, 32'h3000 + 32'(4 * i));
    tick(); tick(); tick(); tick();
    chk("maxout_handshakes", hs_total - h0, MAXO);
    chk("maxout_stalled", out_valid, 0);
    cache_done = 1'b1; tick(); cache_done = 1'b0;
    tick(); tick();
    chk("maxout_after_done", hs_total - h0, MAXO + 1);
    drain();

    // illegal command dropped, spurious done
    e0 = err_seen;
    push(4'd7, 32'h4000);
    push(4'd1, 32'h4004);
    tick(); tick(); tick();
    chk("illegal_err_once", err_seen - e0, 1);
    drain();
    set_mode(0, 0);
    cache_done = 1'b1; tick(); cache_done = 1'b0;
    tick();
    chk("spurious_err", err_seen - e0, 2);
    chk("spurious_busy", busy, 0);

    // randomized traffic
    set_mode(2, 0);
    a = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!(in_valid && !a)) begin
        in_valid = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) == 0) in_cmd = 4'($urandom_range(0, 15));
        else in_cmd = legal_tab[$urandom_range(0, 6)];
        in_addr = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      a = in_valid && in_ready;
      tick();
    end
    drain();

    // reset mid-operation: 2 outstanding, 3 buffered
    set_mode(0, 0);
    out_ready = 1'b1;
    push(4'd0, 32'h5000);
    push(4'd0, 32'h5004);
    tick(); tick();
    chk("mid_outstanding", m_out, 2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(4'd2, 32'h6000 + 32'(i));
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_cmd", out_cmd, 0);
`ifdef DISPATCH_STATS_EN
    chk("stat_rd_zero", stat_rd, 0);
    chk("stat_wr_zero", stat_wr, 0);
    chk("stat_if_zero", stat_if, 0);
    chk("stat_snp_zero", stat_snp, 0);
    chk("stat_drop_zero", stat_drop, 0);
`endif
    e0 = err_seen;
    cache_done = 1'b1; tick(); cache_done = 1'b0;
    tick();
    chk("post_rst_spurious", err_seen - e0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_cmd_dispatcher.md
# trace_cmd_dispatcher

Front-end stage that sits directly upstream of the L1 cache model. It accepts decoded trace records (command code plus 32-bit address) from the trace reader, buffers them in a small FIFO and drops illegal command codes. It then issues records to the cache one at a time over a valid/ready handshake. CLR (8) and PRINT (9) are serializing barriers: they are issued only after every earlier command has been reported complete by the cache.

## Interface
Parameters:
- ADDR_W, 32, address width
- DEPTH, 8, FIFO entries (power of two, ≥2)
- MAX_OUT, 4, maximum issued-but-not-completed commands (1..15)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  trace record present
- in_cmd  in  4  command code
- in_addr  in  ADDR_W  record address
- in_ready  out  1  FIFO can accept (= !full)
- out_valid  out  1  record presented to cache
- out_cmd  out  4  issued command
- out_addr  out  ADDR_W  issued address
- out_ready  in  1  cache accepts record
- cache_done  in  1  one-cycle pulse, one non-barrier command completed
- busy  out  1  FIFO non-empty or outstanding ≠ 0
- err_pulse  out  1  one-cycle pulse: dropped illegal command or spurious cache_done

## Operation
- Legal codes: READ=0, WRITE=1, I_FETCH=2, L2_INVAL=3, L2_DATA_RQ=4, CLR=8, PRINT=9. Codes 5–7 and 10–15 are consumed when in_valid&&in_ready, are never written to the FIFO, and assert err_pulse the next cycle.
- FIFO order is strict; there is no reordering and no bypass.
- Outstanding counter `out_cnt` (4 bits):
  - +1 on a non-barrier handshake (out_valid&&out_ready)
  - −1 on cache_done
  - unchanged when both occur in the same cycle
  - cache_done while out_cnt==0 is ignored and asserts err_pulse
- FSM states:
  - IDLE: FIFO empty, out_valid=0. Goes to ISSUE when the FIFO becomes non-empty.
  - ISSUE: head is non-barrier. out_valid=1 when out_cnt<MAX_OUT. After a handshake, the next state is ISSUE, DRAIN or IDLE, decided by the new head.
  - DRAIN: head is CLR/PRINT. out_valid=0 until out_cnt==0, then goes to BARRIER.
  - BARRIER: out_valid=1 with the barrier record. On handshake, pop the record (out_cnt unchanged) and go to ISSUE, DRAIN or IDLE as above.
- out_cmd/out_addr are stable while out_valid=1 and out_ready=0. Withdrawing a valid is not permitted.
- Reset mid-operation: the FIFO is emptied, out_cnt is cleared and in-flight records are discarded. cache_done pulses after reset count as spurious.

## Timing
- Reset values: in_ready=1, out_valid=0, out_cmd=0, out_addr=0, busy=0, err_pulse=0, FSM=IDLE.
- Output registers are loaded from the FIFO head. A record pushed into an empty FIFO at edge N is presented (out_valid=1) after edge N+1, giving 1 cycle latency.
- Back-to-back issue: with out_ready held high and no MAX_OUT stall, one record per cycle.
- Full FIFO: in_ready=0. A pop in the same cycle does not raise in_ready until the next cycle.
- Barrier release: out_cnt reaching 0 at edge N presents the barrier after edge N+1.
- Pointers wrap modulo DEPTH, with an extra bit for full/empty distinction.

## Configuration
- DISPATCH_STATS_EN defined: adds output ports stat_rd, stat_wr, stat_if, stat_snp, stat_drop (each 32 bits).
  - Each saturating counter increments on its respective event: READ, WRITE, I_FETCH, or L2_INVAL/L2_DATA_RQ handshake, or a dropped illegal command.
  - All clear on rst. CLR passing through does not clear them.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Reset, then push READ 0x0000_1000 with out_ready=1 → out_valid one cycle later, out_cmd=0, out_addr=0x0000_1000; busy=1 until cache_done.
- Push 9 records with out_ready=0, DEPTH=8 → in_ready drops after the 8th push; the 9th is held by the source; release produces in-order output 0..8.
- WRITE, READ, CLR, READ with out_ready=1 and cache_done delayed 5 cycles each → CLR is not presented until 2 done pulses arrive; the final READ issues after the CLR handshake.
- MAX_OUT=4, 6 READs, no cache_done → exactly 4 handshakes; out_valid=0 with out_cnt=4; one done pulse → a 5th handshake follows.
- Push cmd 7 then cmd 1 → err_pulse once; only WRITE appears on the output. Pulse cache_done while idle → err_pulse; out_cnt stays 0.
- Assert rst while 3 records are buffered and 2 are outstanding → next cycle out_valid=0, busy=0, in_ready=1. With DISPATCH_STATS_EN, the stat counters read 0.
